// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, fetch register, fetch counter.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic        misalign_fault
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_fault_q, misalign_fault_d;
  logic        trap;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap = redirect && (redirect_target[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    if_instr_d       = if_instr_q;
    if_pc_d          = if_pc_q;
    if_valid_d       = if_valid_q;
    fetch_count_d    = fetch_count_q;
    misalign_fault_d = misalign_fault_q;
    if (state_q == FAULT) begin
      if_valid_d = 1'b0;
    end else if (trap) begin
      state_d          = FAULT;
      misalign_fault_d = 1'b1;
      if_valid_d       = 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall; the slot being fetched is squashed.
      pc_d       = {redirect_target[31:2], 2'b00};
      if_instr_d = 32'h0000_0000;
      if_pc_d    = pc_q;
      if_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d          = pc_q + 32'd4;
      if_instr_d    = imem_data;
      if_pc_d       = pc_q;
      if_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      pc_q             <= RESET_PC;
      if_instr_q       <= 32'h0000_0000;
      if_pc_q          <= 32'h0000_0000;
      if_valid_q       <= 1'b0;
      fetch_count_q    <= 32'h0000_0000;
      misalign_fault_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_instr_q       <= if_instr_d;
      if_pc_q          <= if_pc_d;
      if_valid_q       <= if_valid_d;
      fetch_count_q    <= fetch_count_d;
      misalign_fault_q <= misalign_fault_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_valid       = if_valid_q;
  assign fetch_count    = fetch_count_q;
  assign misalign_fault = misalign_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed and random stimulus.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] fetch_count;
  logic        misalign_fault;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .fetch_count(fetch_count), .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_data = mem_f(imem_addr);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
    logic        fault;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state of the fetch stage as seen by decode.
  logic [31:0] m_pc = RPC, m_instr = 0, m_ifpc = 0, m_cnt = 0;
  logic        m_valid = 0, m_fault = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, " imem_addr"}, imem_addr, e.addr);
      chk({e.tag, " if_instr"}, if_instr, e.instr);
      chk({e.tag, " if_pc"}, if_pc, e.pc);
      chk({e.tag, " if_valid"}, {31'b0, if_valid}, {31'b0, e.valid});
      chk({e.tag, " fetch_count"}, fetch_count, e.cnt);
      chk({e.tag, " misalign_fault"}, {31'b0, misalign_fault}, {31'b0, e.fault});
    end
  end

  // Applies one cycle of inputs and records what decode must see after the edge.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] t,
                      input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    reset = r; stall = s; redirect = rd; redirect_target = t;
    if (r) begin
      m_pc = RPC; m_instr = 0; m_ifpc = 0; m_valid = 0; m_cnt = 0; m_fault = 0;
    end else if (m_fault) begin
      m_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    end else if (rd && (t % 4 != 0)) begin
      m_fault = 1; m_valid = 0;
`endif
    end else if (rd) begin
      m_ifpc = m_pc; m_instr = 0; m_valid = 0; m_pc = t - (t % 4);
    end else if (!s) begin
      m_instr = mem_f(m_pc); m_ifpc = m_pc; m_valid = 1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc = m_ifpc; e.valid = m_valid;
    e.cnt = m_cnt; e.fault = m_fault; e.tag = tag;
    q.push_back(e);
  endtask

  initial begin
    step(1, 0, 0, 0, "reset");
    step(0, 0, 0, 0, "run0");
    step(0, 0, 0, 0, "run1");
    step(0, 1, 0, 0, "stall0");
    step(0, 1, 0, 0, "stall1");
    step(0, 0, 0, 0, "resume");
    step(0, 1, 1, 32'h40, "redir_stall");
    step(0, 0, 0, 0, "after_redir");
    step(0, 0, 1, 32'hFFFF_FFFC, "redir_top");
    step(0, 0, 0, 0, "wrap");
    step(0, 0, 0, 0, "post_wrap");
    step(0, 0, 1, 32'h42, "misalign");
    step(0, 0, 0, 0, "misalign_hold0");
    step(0, 1, 1, 32'h80, "misalign_hold1");
    step(1, 1, 1, 32'h84, "reset_mid_op");
    step(0, 0, 0, 0, "first_after_reset");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      case ($urandom_range(0, 3))
        0: t = 32'hFFFF_FFF0 | ($urandom_range(0, 15));
        1: t = $urandom & 32'hFFFF_FFFC;
        default: t = $urandom;
      endcase
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), t, "random");
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
